// File: rtl/sap_pkg.sv
// sap_pkg: shared RAM geometry constants and the loader state type
package sap_pkg;
  localparam int RAM_DEPTH = 16;
  localparam int RAM_ADDR_W = 4;
  typedef enum logic [2:0] {IDLE, WAIT_BYTE, LOAD_ADDR, WRITE, VERIFY_ADDR, VERIFY_READ, DONE} loader_state_t;
endpackage

// File: rtl/loader_shadow_mem.sv
// loader_shadow_mem: copy of the program bytes kept for readback comparison
module loader_shadow_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // synchronous write, cleared on reset
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/ram_loader.sv
// ram_loader: streams a program into the RAM over its bus and verifies it by readback
module ram_loader
  import sap_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = 8,
  parameter int DEPTH = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [DATA_W-1:0] ram_bus_out,
  output logic [DATA_W-1:0] bus_drive,
  output logic              bus_drive_en,
  output logic              load_addr_reg,
  output logic              control_signal,
  output logic              output_enable,
  output logic              busy,
  output logic              done,
  output logic              verify_error,
  output logic [ADDR_W-1:0] error_addr
);
  loader_state_t st, st_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [DATA_W-1:0] data, shadow_q;
  logic take, arm, miss, last;
  assign last = addr == ADDR_W'(DEPTH - 1);
  assign take = !abort && st == WAIT_BYTE && byte_valid;
  assign arm = !abort && start && (st == IDLE || st == DONE);
  assign miss = !abort && st == VERIFY_READ && ram_bus_out != shadow_q;
  loader_shadow_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_shadow (
    .clk(clk), .clear_n(clear_n), .we(take), .addr(addr), .wdata(byte_data), .rdata(shadow_q)
  );
  // next state and address; abort overrides everything
  always_comb begin
    st_nx = st;
    addr_nx = addr;
    if (abort) st_nx = IDLE;
    else
      case (st)
        IDLE, DONE: if (start) begin st_nx = WAIT_BYTE; addr_nx = '0; end
        WAIT_BYTE: if (byte_valid) st_nx = LOAD_ADDR;
        LOAD_ADDR: st_nx = WRITE;
        WRITE: begin st_nx = last ? VERIFY_ADDR : WAIT_BYTE; addr_nx = addr + 1'b1; end
        VERIFY_ADDR: st_nx = VERIFY_READ;
        VERIFY_READ: begin st_nx = last ? DONE : VERIFY_ADDR; addr_nx = addr + 1'b1; end
        default: st_nx = IDLE;
      endcase
  end
  // state, counters and outputs registered from the upcoming state
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      st <= IDLE;
      addr <= '0;
      data <= '0;
      byte_ready <= 1'b0;
      bus_drive <= '0;
      bus_drive_en <= 1'b0;
      load_addr_reg <= 1'b0;
      control_signal <= 1'b0;
      output_enable <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= st_nx;
      addr <= addr_nx;
      data <= take ? byte_data : data;
      byte_ready <= st_nx == WAIT_BYTE;
      bus_drive <= (st_nx == LOAD_ADDR || st_nx == VERIFY_ADDR) ? DATA_W'(addr_nx) : st_nx == WRITE ? data : '0;
      bus_drive_en <= st_nx inside {LOAD_ADDR, WRITE, VERIFY_ADDR};
      load_addr_reg <= st_nx inside {LOAD_ADDR, VERIFY_ADDR};
      control_signal <= st_nx == WRITE;
      output_enable <= st_nx == VERIFY_READ;
      busy <= !(st_nx inside {IDLE, DONE});
      done <= st_nx == DONE;
    end
  // first-mismatch capture, cleared when a new run is armed
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      verify_error <= 1'b0;
      error_addr <= '0;
    end else if (arm) begin
      verify_error <= 1'b0;
      error_addr <= '0;
    end else if (miss && !verify_error) begin
      verify_error <= 1'b1;
      error_addr <= addr;
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed checks of ram_loader against a RAM model and a transaction scoreboard
module tb_ram_loader;
  logic clk = 0, clear_n = 0, start = 0, abort = 0, byte_valid = 0;
  logic [7:0] byte_data = 0, ram_bus_out, bus_drive;
  logic byte_ready, bus_drive_en, load_addr_reg, control_signal, output_enable, busy, done, verify_error;
  logic [3:0] error_addr;
  int total = 0, bad = 0;
  logic [7:0] prog [16];
  logic [7:0] ram [16] = '{default: 8'h00};
  logic [3:0] areg = 0;
  logic [15:0] corrupt = 0;
  int wcnt = 0, vcnt = 0;
  int acc_edge [16];
  int de;

  always #5 clk = ~clk;

  ram_loader dut (
    .clk(clk), .clear_n(clear_n), .start(start), .abort(abort), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .ram_bus_out(ram_bus_out),
    .bus_drive(bus_drive), .bus_drive_en(bus_drive_en), .load_addr_reg(load_addr_reg),
    .control_signal(control_signal), .output_enable(output_enable), .busy(busy),
    .done(done), .verify_error(verify_error), .error_addr(error_addr)
  );

  always @(posedge clk) begin
    if (load_addr_reg) areg <= bus_drive[3:0];
    if (control_signal) ram[areg] <= bus_drive;
  end
  assign ram_bus_out = corrupt[areg] ? 8'hFF : ram[areg];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  always @(negedge clk) if (clear_n) begin
    chk("strobe_excl", 32'($onehot0({load_addr_reg, control_signal, output_enable})), 1);
    chk("bus_vs_oe", 32'(bus_drive_en && output_enable), 0);
    if (load_addr_reg) chk("addr_phase", {bus_drive_en, bus_drive}, {1'b1, 8'(wcnt < 16 ? wcnt : vcnt)});
    if (control_signal) begin
      chk("write_data", {bus_drive_en, bus_drive}, {1'b1, prog[wcnt[3:0]]});
      wcnt++;
    end
    if (output_enable) begin
      chk("verify_seq", wcnt, 16);
      vcnt++;
    end
  end

  task automatic run(input int stall_at, input int stall_len, input int abort_at, input int restart_e, output int done_edge);
    int k, st, e;
    logic rdy;
    k = 0; st = 0; e = 0; done_edge = -1;
    wcnt = 0; vcnt = 0;
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    while (e < 300 && done_edge < 0) begin
      @(negedge clk);
      rdy = byte_ready;
      byte_data = prog[k[3:0]];
      byte_valid = k < 16;
      if (rdy && k == stall_at && st < stall_len) begin
        byte_valid = 0;
        st++;
        chk("stall_ready", 32'(byte_ready), 1);
        chk("stall_quiet", {load_addr_reg, control_signal, output_enable, bus_drive_en}, 0);
      end
      abort = rdy && k == abort_at;
      start = e == restart_e;
      @(posedge clk);
      e++;
      #1;
      start = 0;
      if (abort) begin
        abort = 0;
        byte_valid = 0;
        chk("abort_idle", {busy, done, byte_ready, load_addr_reg, control_signal, output_enable, bus_drive_en}, 0);
        return;
      end
      if (rdy && byte_valid) begin
        acc_edge[k] = e;
        k++;
      end
      if (done) done_edge = e;
    end
    byte_valid = 0;
    if (done_edge < 0) chk("timeout", 0, 1);
  endtask

  task automatic check_result(input string n);
    int fa;
    fa = -1;
    for (int a = 15; a >= 0; a--) if ((corrupt[a] ? 8'hFF : ram[a]) != prog[a]) fa = a;
    chk({n, "_verr"}, 32'(verify_error), 32'(fa >= 0));
    if (fa >= 0) chk({n, "_eaddr"}, 32'(error_addr), 32'(fa));
    for (int a = 0; a < 16; a++) chk({n, "_ram"}, 32'(ram[a]), 32'(prog[a]));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = 8'(i);
    #12;
    chk("reset_outs", {byte_ready, bus_drive, bus_drive_en, load_addr_reg, control_signal, output_enable, busy, done, verify_error, error_addr}, 0);
    @(negedge clk) clear_n = 1;
    // reset while a write strobe is high
    @(negedge clk) start = 1;
    byte_valid = 1;
    byte_data = prog[0];
    @(negedge clk) start = 0;
    for (int i = 0; i < 20 && !control_signal; i++) @(negedge clk);
    chk("saw_write", 32'(control_signal), 1);
    clear_n = 0;
    #1;
    chk("async_clr", {control_signal, busy, byte_ready, bus_drive_en, load_addr_reg, bus_drive}, 0);
    byte_valid = 0;
    @(negedge clk) clear_n = 1;
    // full stream, valid held high
    run(-1, 0, -1, -1, de);
    chk("done_edge", de, 80);
    for (int k = 0; k < 16; k++) chk("accept_edge", acc_edge[k], 1 + 3 * k);
    chk("verr_clean", 32'(verify_error), 0);
    check_result("stream");
    // host stalls before byte 7
    for (int i = 0; i < 16; i++) prog[i] = 8'(8'h20 + i);
    run(7, 5, -1, -1, de);
    chk("stall_done", de, 85);
    chk("stall_acc7", acc_edge[7], 27);
    chk("stall_acc8", acc_edge[8], 30);
    check_result("stall");
    // RAM corrupts 0x9 and 0xC
    for (int i = 0; i < 16; i++) prog[i] = 8'(8'h40 + i);
    corrupt[9] = 1;
    corrupt[12] = 1;
    run(-1, 0, -1, -1, de);
    chk("corr_done", de, 80);
    chk("corr_verr", 32'(verify_error), 1);
    chk("corr_eaddr", 32'(error_addr), 9);
    check_result("corr");
    repeat (3) @(negedge clk);
    chk("done_held", {done, busy}, 2'b10);
    corrupt = 0;
    // abort with a byte offered during byte 4
    for (int i = 0; i < 16; i++) prog[i] = 8'(8'h60 + i);
    run(-1, 0, 4, -1, de);
    repeat (3) @(negedge clk);
    chk("abort_ram4", 32'(ram[4]), 32'h44);
    chk("abort_ram3", 32'(ram[3]), 32'h63);
    chk("abort_state", {busy, done, verify_error}, 0);
    // start while busy is ignored
    for (int i = 0; i < 16; i++) prog[i] = 8'(8'h80 + i);
    run(-1, 0, -1, 20, de);
    chk("rst_busy_done", de, 80);
    check_result("restart");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end
endmodule
